// File: rtl/ifu_fetch_ctrl.sv
// Purpose: instruction-fetch sequencer; owns the PC, issues one imem request at a time, presents word+PC to decode.
// Latency: first imem_req the cycle after rst falls; inst_valid rises the cycle after imem_rvalid (>= 3 cycles/instr).
// Backpressure: holds the fetched entry stable and issues no request while inst_valid=1 and inst_ready=0.
//
// Ports:
//   clk, rst                      rising-edge clock, synchronous active-high reset
//   redirect_valid, redirect_pc   branch/jump redirect from execute (highest priority)
//   imem_req, imem_addr           fetch request / address (address = PC, word aligned)
//   imem_gnt                      request accepted this cycle
//   imem_rvalid, imem_rdata       one response per granted request
//   inst_valid, inst_ready        valid/ready handshake towards decode
//   inst_pc, inst_data            presented PC and instruction word
//   inst_misalign                 presented entry is a misaligned-fetch fault (inst_data=0)
module ifu_fetch_ctrl #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [63:0] inst_pc,
  output logic [31:0] inst_data,
  output logic        inst_misalign
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [63:0] pc, pc_nxt;
  logic        discard, discard_nxt;
  logic [63:0] inst_pc_nxt;
  logic [31:0] inst_data_nxt;
  logic        inst_misalign_nxt;
  logic        redirect_misalign;

  assign redirect_misalign = (redirect_pc[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_REQ;
      pc            <= RESET_PC;
      discard       <= 1'b0;
      inst_pc       <= 64'd0;
      inst_data     <= 32'd0;
      inst_misalign <= 1'b0;
    end else begin
      state         <= state_nxt;
      pc            <= pc_nxt;
      discard       <= discard_nxt;
      inst_pc       <= inst_pc_nxt;
      inst_data     <= inst_data_nxt;
      inst_misalign <= inst_misalign_nxt;
    end
  end

  always_comb begin
    state_nxt         = state;
    pc_nxt            = pc;
    discard_nxt       = discard;
    inst_pc_nxt       = inst_pc;
    inst_data_nxt     = inst_data;
    inst_misalign_nxt = inst_misalign;

    if (redirect_valid) begin
      // A response is still owed after this edge if a request is granted now,
      // or one was already in flight and does not return in this cycle.
      discard_nxt = ((state == S_REQ)  && imem_gnt) ||
                    ((state == S_WAIT) && !imem_rvalid) ||
                    ((state == S_HOLD) && discard && !imem_rvalid);
      if (redirect_misalign) begin
        // Fault entry goes straight to decode. The PC keeps the word-aligned
        // target so any later fetch before the trap redirect is aligned.
        pc_nxt            = {redirect_pc[63:2], 2'b00};
        state_nxt         = S_HOLD;
        inst_pc_nxt       = redirect_pc;
        inst_data_nxt     = 32'd0;
        inst_misalign_nxt = 1'b1;
      end else begin
        pc_nxt    = redirect_pc;
        // Never issue a new request while a response is still outstanding.
        state_nxt = discard_nxt ? S_WAIT : S_REQ;
      end
    end else begin
      unique case (state)
        S_REQ: begin
          if (imem_gnt) state_nxt = S_WAIT;
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            if (discard) begin
              discard_nxt = 1'b0;
              state_nxt   = S_REQ;
            end else begin
              inst_pc_nxt       = pc;
              inst_data_nxt     = imem_rdata;
              inst_misalign_nxt = 1'b0;
              pc_nxt            = pc + 64'd4;
              state_nxt         = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          // Only a misaligned entry can sit here with a stale response pending.
          if (imem_rvalid && discard) discard_nxt = 1'b0;
          if (inst_ready && !discard) state_nxt = S_REQ;
        end
        default: state_nxt = S_REQ;
      endcase
    end
  end

  assign imem_req   = (state == S_REQ) && !rst;
  assign imem_addr  = pc;
  assign inst_valid = (state == S_HOLD);

  a_rvalid_expected: assert property (@(posedge clk) disable iff (rst)
    imem_rvalid |-> ((state == S_WAIT) || discard));

  a_hold_stable: assert property (@(posedge clk) disable iff (rst)
    (inst_valid && !inst_ready && !redirect_valid) |=> ($stable(inst_pc) && $stable(inst_data)));

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
module tb_ifu_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [63:0] inst_pc;
  logic [31:0] inst_data;
  logic        inst_misalign;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  ifu_fetch_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_pc        (inst_pc),
    .inst_data      (inst_data),
    .inst_misalign  (inst_misalign)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 64'd0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0; inst_ready = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst_req",      {63'd0, imem_req},      64'd0);
    chk("rst_valid",    {63'd0, inst_valid},    64'd0);
    chk("rst_inst_pc",  inst_pc,                64'd0);
    chk("rst_inst_dat", {32'd0, inst_data},     64'd0);
    chk("rst_misalign", {63'd0, inst_misalign}, 64'd0);
    rst = 1'b0;
    #1;

    // 1: basic fetch
    chk("t1_req",  {63'd0, imem_req}, 64'd1);
    chk("t1_addr", imem_addr, 64'h8000_0000);
    imem_gnt = 1'b1; tick(); imem_gnt = 1'b0;
    chk("t1_wait_req", {63'd0, imem_req}, 64'd0);
    chk("t1_wait_vld", {63'd0, inst_valid}, 64'd0);
    imem_rvalid = 1'b1; imem_rdata = 32'h0000_0013; tick(); imem_rvalid = 1'b0;
    chk("t1_vld",  {63'd0, inst_valid}, 64'd1);
    chk("t1_pc",   inst_pc, 64'h8000_0000);
    chk("t1_data", {32'd0, inst_data}, 64'h13);
    chk("t1_mis",  {63'd0, inst_misalign}, 64'd0);
    chk("t1_hold_req", {63'd0, imem_req}, 64'd0);
    inst_ready = 1'b1; tick(); inst_ready = 1'b0;
    chk("t1_vld_drop", {63'd0, inst_valid}, 64'd0);
    chk("t1_next_req", {63'd0, imem_req}, 64'd1);
    chk("t1_next_addr", imem_addr, 64'h8000_0004);

    // 2: backpressure in HOLD
    imem_gnt = 1'b1; tick(); imem_gnt = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'h0010_0093; tick(); imem_rvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("t2_vld",  {63'd0, inst_valid}, 64'd1);
      chk("t2_pc",   inst_pc, 64'h8000_0004);
      chk("t2_data", {32'd0, inst_data}, 64'h0010_0093);
      chk("t2_noreq", {63'd0, imem_req}, 64'd0);
      tick();
    end
    chk("t2_still_vld", {63'd0, inst_valid}, 64'd1);
    inst_ready = 1'b1; tick(); inst_ready = 1'b0;
    chk("t2_vld_drop", {63'd0, inst_valid}, 64'd0);
    chk("t2_req",  {63'd0, imem_req}, 64'd1);
    chk("t2_addr", imem_addr, 64'h8000_0008);

    // 4: redirect in the same cycle as gnt
    imem_gnt = 1'b1; redirect_valid = 1'b1; redirect_pc = 64'h8000_2000;
    tick(); imem_gnt = 1'b0; redirect_valid = 1'b0;
    chk("t4_wait_req", {63'd0, imem_req}, 64'd0);
    imem_rvalid = 1'b1; imem_rdata = 32'hCAFE_F00D; tick(); imem_rvalid = 1'b0;
    chk("t4_drop_vld", {63'd0, inst_valid}, 64'd0);
    chk("t4_req",  {63'd0, imem_req}, 64'd1);
    chk("t4_addr", imem_addr, 64'h8000_2000);

    // 3: redirect while in WAIT, late response
    imem_gnt = 1'b1; tick(); imem_gnt = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 64'h8000_1000; tick(); redirect_valid = 1'b0;
    chk("t3_wait_req", {63'd0, imem_req}, 64'd0);
    chk("t3_wait_vld", {63'd0, inst_valid}, 64'd0);
    tick();
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF; tick(); imem_rvalid = 1'b0;
    chk("t3_drop_vld", {63'd0, inst_valid}, 64'd0);
    chk("t3_req",  {63'd0, imem_req}, 64'd1);
    chk("t3_addr", imem_addr, 64'h8000_1000);

    // 5: misaligned redirect in HOLD, dropped even with inst_ready=1
    imem_gnt = 1'b1; tick(); imem_gnt = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'h1111_1111; tick(); imem_rvalid = 1'b0;
    chk("t5_pre_pc", inst_pc, 64'h8000_1000);
    inst_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 64'h8000_0006;
    tick(); inst_ready = 1'b0; redirect_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t5_vld",  {63'd0, inst_valid}, 64'd1);
      chk("t5_mis",  {63'd0, inst_misalign}, 64'd1);
      chk("t5_pc",   inst_pc, 64'h8000_0006);
      chk("t5_data", {32'd0, inst_data}, 64'd0);
      chk("t5_noreq", {63'd0, imem_req}, 64'd0);
      tick();
    end
    inst_ready = 1'b1; tick(); inst_ready = 1'b0;
    chk("t5_vld_drop", {63'd0, inst_valid}, 64'd0);
    chk("t5_req",  {63'd0, imem_req}, 64'd1);
    chk("t5_addr", imem_addr, 64'h8000_0004);

    // 5b: misaligned redirect from WAIT; HOLD waits out the stale response
    imem_gnt = 1'b1; tick(); imem_gnt = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 64'h8000_0102; tick(); redirect_valid = 1'b0;
    inst_ready = 1'b1; tick();
    chk("t5b_vld_pending", {63'd0, inst_valid}, 64'd1);
    chk("t5b_noreq",       {63'd0, imem_req}, 64'd0);
    imem_rvalid = 1'b1; imem_rdata = 32'h2222_2222; tick(); imem_rvalid = 1'b0;
    chk("t5b_vld_resp", {63'd0, inst_valid}, 64'd1);
    chk("t5b_mis",      {63'd0, inst_misalign}, 64'd1);
    chk("t5b_pc",       inst_pc, 64'h8000_0102);
    tick(); inst_ready = 1'b0;
    chk("t5b_vld_drop", {63'd0, inst_valid}, 64'd0);
    chk("t5b_req",  {63'd0, imem_req}, 64'd1);
    chk("t5b_addr", imem_addr, 64'h8000_0100);

    // 6: gnt withheld, then reset pulse
    for (int i = 0; i < 4; i++) begin
      chk("t6_req_hold",  {63'd0, imem_req}, 64'd1);
      chk("t6_addr_hold", imem_addr, 64'h8000_0100);
      tick();
    end
    rst = 1'b1; #1;
    chk("t6_rst_noreq", {63'd0, imem_req}, 64'd0);
    tick(); rst = 1'b0; #1;
    chk("t6_req",  {63'd0, imem_req}, 64'd1);
    chk("t6_addr", imem_addr, 64'h8000_0000);
    chk("t6_vld",  {63'd0, inst_valid}, 64'd0);

    // 6b: PC wrap via redirect
    redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC; tick(); redirect_valid = 1'b0;
    chk("t6_wrap_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    imem_gnt = 1'b1; tick(); imem_gnt = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'h0000_006F; tick(); imem_rvalid = 1'b0;
    chk("t6_wrap_pc",   inst_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("t6_wrap_data", {32'd0, inst_data}, 64'h6F);
    inst_ready = 1'b1; tick(); inst_ready = 1'b0;
    chk("t6_wrap_req",  {63'd0, imem_req}, 64'd1);
    chk("t6_wrap_next", imem_addr, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
